// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and elaboration helpers for the flagged sync FIFO
package fifo_pkg;

   localparam int FWFT_STD  = 0;
   localparam int FWFT_FALL = 1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Thresholds must be ordered and must fit the occupancy counter.
   function automatic bit params_legal(input int addr_width, input int almost_full,
                                       input int almost_empty);
      int depth;
      depth = 1 << addr_width;
      return (almost_empty >= 0) && (almost_empty < almost_full) &&
             (almost_full <= depth) && (almost_full >= 1) &&
             (clog2(almost_full + 1) <= addr_width + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - 1W/1R storage array with combinational or registered read port
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int ASYNC_RD   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (ASYNC_RD != 0) begin : g_async_rd
         logic unused_rd_ctrl;
         assign unused_rd_ctrl = rst ^ re;
         assign rdata = mem_q[raddr];
      end else begin : g_sync_rd
         // Only the output register is reset; the array itself never is.
         logic [DATA_WIDTH-1:0] rdata_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q <= '0;
            end else if (re) begin
               rdata_q <= mem_q[raddr];
            end
         end
         assign rdata = rdata_q;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, almost flags, FWFT mode and sticky errors
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 4,
   parameter int FWFT         = 0,
   parameter int ALMOST_FULL  = 14,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(ALMOST_FULL);
   localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

   generate
      if (!params_legal(ADDR_WIDTH, ALMOST_FULL, ALMOST_EMPTY)) begin : g_param_err
         $error("sync_fifo_flags: illegal ALMOST_FULL/ALMOST_EMPTY for ADDR_WIDTH");
      end
   endgenerate

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Every flag is a function of the registered pointers only.
   assign count        = wr_ptr_q - rd_ptr_q;
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                         (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_acc      = wr_en & ~full;
      rd_acc      = rd_en & ~empty;
      wr_ptr_d    = wr_ptr_q + (ADDR_WIDTH + 1)'(wr_acc);
      rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH + 1)'(rd_acc);
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en & full) begin
         overflow_d = 1'b1;
      end
      if (rd_en & empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ASYNC_RD   ((FWFT == FWFT_FALL) ? 1 : 0)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT == FWFT_FALL) begin : g_dout_fwft
         assign dout = empty ? '0 : mem_rdata;
      end else begin : g_dout_std
         assign dout = mem_rdata;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized bench with queue model for standard and FWFT FIFO builds
module tb_sync_fifo_flags;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] din = '0;

   logic [15:0] s_dout, f_dout;
   logic        s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic        f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [4:0]  s_count, f_count;

   int          total = 0;
   int          passed = 0;
   int          q[$];
   bit          m_ovf, m_unf;
   logic [15:0] m_dout;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .ALMOST_FULL(14), .ALMOST_EMPTY(2)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
      .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .count(s_count), .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr));

   sync_fifo_flags #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .ALMOST_FULL(14), .ALMOST_EMPTY(2)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = '0;
   endtask

   task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c);
      bit fm, em;
      wr_en = w; din = d; rd_en = r; err_clr = c;
      @(posedge clk);
      fm = (q.size() == 16);
      em = (q.size() == 0);
      if (r && !em) m_dout = 16'(q.pop_front());
      if (w && !fm) q.push_back(int'(d));
      if (w && fm) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && em) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmp_dut(input string tag, input logic [15:0] dv, input logic fl, input logic em,
                          input logic af, input logic ae, input logic [4:0] cnt,
                          input logic ov, input logic un, input bit fw);
      int n;
      n = q.size();
      chk({tag, "_count"}, 32'(cnt), n);
      chk({tag, "_empty"}, 32'(em), 32'(n == 0));
      chk({tag, "_full"}, 32'(fl), 32'(n == 16));
      chk({tag, "_afull"}, 32'(af), 32'(n >= 14));
      chk({tag, "_aempty"}, 32'(ae), 32'(n <= 2));
      chk({tag, "_overflow"}, 32'(ov), 32'(m_ovf));
      chk({tag, "_underflow"}, 32'(un), 32'(m_unf));
      if (!fw) chk({tag, "_dout"}, 32'(dv), 32'(m_dout));
      else if (n > 0) chk({tag, "_dout"}, 32'(dv), q[0]);
   endtask

   always @(negedge clk) begin
      cmp_dut("std", s_dout, s_full, s_empty, s_af, s_ae, s_count, s_ovf, s_unf, 1'b0);
      cmp_dut("fwft", f_dout, f_full, f_empty, f_af, f_ae, f_count, f_ovf, f_unf, 1'b1);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wp, rp;
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_count", 32'(s_count), 0);
      chk("rst_empty", 32'(s_empty), 1);
      chk("rst_aempty", 32'(s_ae), 1);

      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 16'(i), 1'b0, 1'b0);
         if (i == 13) chk("afull_at_13", 32'(s_af), 0);
         if (i == 14) chk("afull_at_14", 32'(s_af), 1);
         if (i == 15) chk("full_at_15", 32'(s_full), 0);
      end
      chk("full_at_16", 32'(s_full), 1);
      step(1'b1, 16'h0011, 1'b0, 1'b0);
      chk("ovf_17th", 32'(s_ovf), 1);
      chk("count_17th", 32'(s_count), 16);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(s_ovf), 0);
      step(1'b1, 16'h0022, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(s_ovf), 1);
      step(1'b0, 16'h0, 1'b0, 1'b1);

      step(1'b1, 16'h0077, 1'b1, 1'b0);
      chk("full_both_count", 32'(s_count), 15);
      chk("full_both_dout", 32'(s_dout), 32'h1);
      for (int i = 2; i <= 16; i++) begin
         step(1'b0, 16'h0, 1'b1, 1'b0);
         chk($sformatf("drain_%0d", i), 32'(s_dout), i);
         if (i == 13) chk("aempty_at_3", 32'(s_ae), 0);
         if (i == 14) chk("aempty_at_2", 32'(s_ae), 1);
      end
      chk("drained_empty", 32'(s_empty), 1);

      step(1'b1, 16'h1234, 1'b1, 1'b0);
      chk("empty_both_count", 32'(s_count), 1);
      chk("empty_both_unf", 32'(s_unf), 1);
      chk("empty_both_fwft", 32'(f_dout), 32'h1234);
      step(1'b0, 16'h0, 1'b1, 1'b1);
      chk("unf_clr", 32'(s_unf), 0);

      for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      step(1'b1, 16'h0105, 1'b1, 1'b0);
      chk("mid_both_count", 32'(s_count), 5);
      chk("mid_both_dout", 32'(s_dout), 32'h0100);
      repeat (5) step(1'b0, 16'h0, 1'b1, 1'b0);

      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) step(1'b1, 16'(16'h0200 + r * 16 + k), 1'b0, 1'b0);
         for (int k = 0; k < 10; k++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("wrap_%0d_%0d", r, k), 32'(s_dout), 32'h0200 + r * 16 + k);
         end
         chk($sformatf("wrap_count_%0d", r), 32'(s_count), 0);
      end

      step(1'b1, 16'hABCD, 1'b0, 1'b0);
      chk("fwft_empty", 32'(f_empty), 0);
      chk("fwft_dout", 32'(f_dout), 32'hABCD);
      chk("std_dout_hold", 32'(s_dout), 32'h0229);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("std_dout_lat", 32'(s_dout), 32'hABCD);

      for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0);
      chk("pre_rst_count", 32'(s_count), 7);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_count", 32'(s_count), 0);
      chk("async_rst_empty", 32'(s_empty), 1);
      chk("async_rst_fcount", 32'(f_count), 0);
      chk("async_rst_dout", 32'(s_dout), 0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 16'h5A5A, 1'b0, 1'b0);
      chk("post_rst_fwft", 32'(f_dout), 32'h5A5A);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("post_rst_std", 32'(s_dout), 32'h5A5A);

      for (int i = 0; i < 3000; i++) begin
         wp = ((i / 400) % 2 == 0) ? 75 : 30;
         rp = 100 - wp;
         step($urandom_range(0, 99) < wp, 16'($urandom), $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 4);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
